vram_write_queue: RTL and testbench

- Parametrised successor to the combinational VRAM address decoder.
- Accepts Avalon-MM slave writes from the HPS bridge and decodes them into NUM_REGIONS memory regions (tile buffer, tile graphics, sprite graphics, palettes, OAM by default).
- Buffers each write in an in-order FIFO and replays it to the target memory as a one-cycle write strobe with a region-relative address.
- Regions flagged in GATE_MASK are committed only while vblank is high, which prevents mid-frame tearing.

---
 rtl/vram_write_queue.sv | 167 ++++++++++++++++
 tb/tb_vram_write_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue.sv
// Purpose: decode HPS Avalon writes into VRAM regions, queue them in order, replay as one-cycle strobes.
// Latency: accept at edge k drains at k+1 at the earliest (mem_we high k+1..k+2); no same-edge bypass.
// Backpressure: waitrequest high while the FIFO holds FIFO_DEPTH entries; a gated head stalls all younger writes.
//
// Ports: clk/reset_n (async active-low); Avalon slave chip_select/write/address/writedata/waitrequest;
//        vblank gates commits to GATE_MASK regions; mem_we/mem_addr/mem_wdata drive the region memories;
//        fifo_level is current occupancy; err_unmapped is sticky for writes below the lowest base (cleared by err_clear).

// Generic single-clock FIFO: registered level counter, wrapping pointers, head visible combinationally.
// Latency: an entry pushed at edge k is visible on head_dat after edge k.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so plain binary wrap is modulo depth.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; the pointers/level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

module vram_write_queue #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_REGIONS = 5,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {12'hE00, 12'hC00, 12'h800, 12'h400, 12'h000},
    parameter logic [NUM_REGIONS-1:0] GATE_MASK = 5'b11000,
    parameter int FIFO_DEPTH  = 8,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   chip_select,
    input  logic                   write,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      writedata,
    output logic                   waitrequest,
    input  logic                   vblank,
    input  logic                   err_clear,
    output logic [NUM_REGIONS-1:0] mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   err_unmapped
);

    localparam int REG_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef struct packed {
        logic [REG_W-1:0]  region;
        logic [ADDR_W-1:0] addr;   // already region-relative
        logic [DATA_W-1:0] dat;
    } wr_ent_t;

    localparam int ENT_W = $bits(wr_ent_t);

    logic             accept;
    logic             dec_hit;
    logic [REG_W-1:0] dec_region;
    logic [ADDR_W-1:0] dec_base;
    logic             push;
    logic             drain;
    wr_ent_t          push_ent;
    wr_ent_t          head;
    logic [ENT_W-1:0] head_dat;

    // Level-based stall: a pop on the same edge does not free a slot until the next cycle.
    assign waitrequest = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign accept      = chip_select && write && !waitrequest;

    // Bases are ascending, so the last matching slice is the highest region containing the address.
    always_comb begin
        dec_hit    = 1'b0;
        dec_region = '0;
        dec_base   = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (address >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit    = 1'b1;
                dec_region = REG_W'(i);
                dec_base   = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign push            = accept && dec_hit;
    assign push_ent.region = dec_region;
    assign push_ent.addr   = address - dec_base;
    assign push_ent.dat    = writedata;

    fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (push),
        .push_dat (push_ent),
        .pop      (drain),
        .head_dat (head_dat),
        .level    (fifo_level)
    );

    assign head = head_dat;

    // Only the head is considered: a gated head outside vblank blocks everything behind it.
    assign drain = (fifo_level != '0) && (!GATE_MASK[head.region] || vblank);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_unmapped <= 1'b0;
        end else begin
            if (drain) begin
                mem_we    <= NUM_REGIONS'(1) << head.region;
                mem_addr  <= head.addr;
                mem_wdata <= head.dat;
            end else begin
                mem_we    <= '0;
            end
            // A new unmapped write takes priority over a clear on the same edge.
            if (accept && !dec_hit) begin
                err_unmapped <= 1'b1;
            end else if (err_clear) begin
                err_unmapped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_queue.sv
// Purpose: self-checking bench for vram_write_queue against a queue-based reference model.
// Latency: model mirrors accept-then-drain-next-edge timing; outputs sampled on the falling edge.
// Backpressure: model stalls on a full queue using the pre-edge occupancy.
module tb_vram_write_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        chip_select = 1'b0;
    logic        cs2 = 1'b0;
    logic        write = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] writedata = '0;
    logic        vblank = 1'b0;
    logic        err_clear = 1'b0;

    logic        waitrequest, waitrequest2;
    logic [4:0]  mem_we, mem_we2;
    logic [11:0] mem_addr, mem_addr2;
    logic [31:0] mem_wdata, mem_wdata2;
    logic [3:0]  fifo_level, fifo_level2;
    logic        err_unmapped, err_unmapped2;

    always #5 clk = ~clk;

    vram_write_queue u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chip_select  (chip_select),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .vblank       (vblank),
        .err_clear    (err_clear),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .fifo_level   (fifo_level),
        .err_unmapped (err_unmapped)
    );

    // Second instance with the lowest base raised so that an unmapped hole exists.
    vram_write_queue #(
        .REGION_BASE ({12'hE00, 12'hC00, 12'h800, 12'h400, 12'h010})
    ) u_dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .chip_select  (cs2),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .waitrequest  (waitrequest2),
        .vblank       (vblank),
        .err_clear    (err_clear),
        .mem_we       (mem_we2),
        .mem_addr     (mem_addr2),
        .mem_wdata    (mem_wdata2),
        .fifo_level   (fifo_level2),
        .err_unmapped (err_unmapped2)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          region;
        int          rel;
        logic [31:0] dat;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  e_we = '0;
    logic [11:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic        e_err = 1'b0;
    bit          last_acc;
    int          bases[5] = '{'h000, 'h400, 'h800, 'hC00, 'hE00};
    bit          gated[5] = '{0, 0, 0, 1, 1};

    function automatic int region_of(input int a);
        int r = -1;
        for (int i = 0; i < 5; i++) if (a >= bases[i]) r = i;
        return r;
    endfunction

    task automatic model_edge();
        bit   acc, drn, unm;
        ent_t e;
        int   r;
        acc = chip_select && write && (q.size() < DEPTH);
        drn = (q.size() > 0) && (!gated[q[0].region] || vblank);
        unm = 1'b0;
        if (drn) begin
            e       = q.pop_front();
            e_we    = 5'(1 << e.region);
            e_addr  = 12'(e.rel);
            e_wdata = e.dat;
        end else begin
            e_we = '0;
        end
        if (acc) begin
            r = region_of(int'(address));
            if (r < 0) unm = 1'b1;
            else q.push_back('{r, int'(address) - bases[r], writedata});
        end
        if (unm) e_err = 1'b1;
        else if (err_clear) e_err = 1'b0;
        last_acc = acc;
    endtask

    task automatic model_reset();
        q.delete();
        e_we = '0; e_addr = '0; e_wdata = '0; e_err = 1'b0;
    endtask

    task automatic check_outputs();
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("fifo_level", fifo_level, q.size());
        chk("waitrequest", waitrequest, q.size() == DEPTH);
        chk("err_unmapped", err_unmapped, e_err);
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic step(input logic cs, input logic wr, input logic [11:0] a,
                        input logic [31:0] d, input logic vb, input logic ec);
        chip_select = cs; write = wr; address = a; writedata = d; vblank = vb; err_clear = ec;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic vb);
        step(1'b0, 1'b0, 12'h000, 32'h0, vb, 1'b0);
    endtask

    // Asserts reset at the current (falling-edge) time and checks the asynchronous clear.
    task automatic do_reset();
        chip_select = 1'b0; cs2 = 1'b0; write = 1'b0; err_clear = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mem_we", mem_we, 5'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_waitreq", waitrequest, 1'b0);
        chk("rst_addr", mem_addr, 12'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_err", err_unmapped, 1'b0);
        chk("rst_err2", err_unmapped2, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        logic vb;

        @(negedge clk);
        do_reset();

        // Single ungated write to tile graphics.
        step(1'b1, 1'b1, 12'h405, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("t1_level_after_accept", fifo_level, 4'd1);
        idle(1'b0);
        chk("t1_we", mem_we, 5'b00010);
        chk("t1_addr", mem_addr, 12'h005);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_level", fifo_level, 4'd0);
        idle(1'b0);
        chk("t1_we_one_cycle", mem_we, 5'b00000);

        // Gated OAM write waits for vblank.
        step(1'b1, 1'b1, 12'hE03, 32'h12, 1'b0, 1'b0);
        repeat (20) idle(1'b0);
        chk("t2_we_blocked", mem_we, 5'b00000);
        chk("t2_level", fifo_level, 4'd1);
        idle(1'b1);
        chk("t2_we", mem_we, 5'b10000);
        chk("t2_addr", mem_addr, 12'h003);
        idle(1'b0);

        // A gated palette write holds back a younger ungated tile-buffer write.
        step(1'b1, 1'b1, 12'hC01, 32'hAAAA0001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 12'h000, 32'hBBBB0002, 1'b0, 1'b0);
        repeat (5) idle(1'b0);
        chk("t3_we_blocked", mem_we, 5'b00000);
        chk("t3_level", fifo_level, 4'd2);
        idle(1'b1);
        chk("t3_we_first", mem_we, 5'b01000);
        chk("t3_addr_first", mem_addr, 12'h001);
        idle(1'b1);
        chk("t3_we_second", mem_we, 5'b00001);
        chk("t3_wdata_second", mem_wdata, 32'hBBBB0002);
        idle(1'b0);

        // Fill with OAM writes outside vblank; the ninth is held by waitrequest.
        for (int i = 0; i < 8; i++) begin
            cnt = 0;
            do begin
                step(1'b1, 1'b1, 12'(12'hE00 + i), 32'(i), 1'b0, 1'b0);
                cnt++;
            end while (!last_acc && cnt < 20);
            if (!last_acc) chk("t4_accept_timeout", 1'b0, 1'b1);
        end
        chk("t4_level_full", fifo_level, 4'd8);
        chk("t4_waitreq_full", waitrequest, 1'b1);
        repeat (3) step(1'b1, 1'b1, 12'hE08, 32'd8, 1'b0, 1'b0);
        chk("t4_still_full", fifo_level, 4'd8);
        cnt = 0;
        step(1'b1, 1'b1, 12'hE08, 32'd8, 1'b1, 1'b0);
        if (mem_we == 5'b10000) cnt++;
        chk("t4_waitreq_drop", waitrequest, 1'b0);
        chk("t4_level_after_pop", fifo_level, 4'd7);
        step(1'b1, 1'b1, 12'hE08, 32'd8, 1'b1, 1'b0);
        if (mem_we == 5'b10000) cnt++;
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            if (mem_we == 5'b10000) cnt++;
        end
        chk("t4_strobes", cnt, 9);
        chk("t4_last_wdata", mem_wdata, 32'd8);
        idle(1'b0);

        // Unmapped write on the instance with a raised lowest base.
        cs2 = 1'b1;
        step(1'b0, 1'b1, 12'h004, 32'h55, 1'b0, 1'b0);
        cs2 = 1'b0;
        chk("t5_err_set", err_unmapped2, 1'b1);
        chk("t5_no_stall", waitrequest2, 1'b0);
        chk("t5_not_pushed", fifo_level2, 4'd0);
        idle(1'b0);
        chk("t5_no_strobe", mem_we2, 5'b00000);
        chk("t5_err_sticky", err_unmapped2, 1'b1);
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1);
        chk("t5_err_cleared", err_unmapped2, 1'b0);
        cs2 = 1'b1;
        step(1'b0, 1'b1, 12'h00F, 32'h66, 1'b0, 1'b1);
        cs2 = 1'b0;
        chk("t5_set_wins", err_unmapped2, 1'b1);
        cs2 = 1'b1;
        step(1'b0, 1'b1, 12'h010, 32'h77, 1'b0, 1'b1);
        cs2 = 1'b0;
        chk("t5_clear_on_mapped", err_unmapped2, 1'b0);
        idle(1'b0);
        chk("t5_base_we", mem_we2, 5'b00001);
        chk("t5_base_addr", mem_addr2, 12'h000);
        chk("t5_base_wdata", mem_wdata2, 32'h77);

        // Reset in the middle of draining queued gated writes.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 12'(12'hE10 + i), 32'(100 + i), 1'b0, 1'b0);
        idle(1'b1);
        chk("t6_draining", mem_we, 5'b10000);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (mem_we != 5'b00000) cnt++;
        end
        chk("t6_no_strobes", cnt, 0);

        // Randomised traffic with slowly toggling vblank.
        vb = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) vb = ~vb;
            step(($urandom_range(2) != 0), ($urandom_range(3) != 0),
                 12'($urandom_range(4095)), $urandom,
                 vb, ($urandom_range(19) == 0));
        end
        for (int i = 0; i < 12; i++) idle(1'b1);
        chk("rand_drained", fifo_level, 4'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
